gold_code_gen: RTL and testbench

Parametrised multi-channel Gold code generator: one shared G1 LFSR and CHANNELS independent G2 LFSRs. Each channel's output chip is the XOR of the G1 and G2 output stages. It generalises the single-channel fixed GPS C/A generator with:
- programmable polynomials, width and code length (short-cycling);
- per-channel runtime-loadable G2 initial states;
- a chip-advance enable, an epoch restart and an epoch strobe.

It sits between the chip-rate timing logic and the correlator/output mux.

---
 rtl/gold_code_gen.sv | 113 +++++++++++
 tb/tb_gold_code_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gold_code_gen.sv
// Multi-channel Gold code generator: one shared G1 LFSR plus CHANNELS independent G2
// LFSRs, each with a runtime-loadable initial state and a programmable epoch length.
module gold_code_gen #(
  parameter int           N        = 10,
  parameter logic [N-1:0] G1_POLY  = 10'h204,
  parameter logic [N-1:0] G2_POLY  = 10'h3A6,
  parameter logic [N-1:0] G1_INIT  = 10'h3FF,
  parameter logic [N-1:0] G2_INIT  = 10'h3FF,
  parameter int           CODE_LEN = 1023,
  parameter int           CHANNELS = 2,
  localparam int          CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int          IDX_W    = $clog2(CODE_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [N-1:0]        load_state,
  output logic [CHANNELS-1:0] chip_out,
  output logic [IDX_W-1:0]    chip_idx,
  output logic                epoch
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

  logic [N-1:0]     g1_q;
  logic [N-1:0]     g1_d;
  logic [N-1:0]     g2_q   [CHANNELS];
  logic [N-1:0]     g2_d   [CHANNELS];
  logic [N-1:0]     init_q [CHANNELS];
  logic [N-1:0]     init_d [CHANNELS];
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;
  logic             epoch_q;
  logic             epoch_d;
  logic             wrap;
  logic             restart;

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s,
                                             input logic [N-1:0] poly);
    return {s[N-2:0], ^(s & poly)};
  endfunction

  // A wrap is an advance out of the last chip; sync overrides it, so no epoch strobe then.
  assign wrap    = en && (cnt_q == LAST_IDX);
  assign restart = sync || wrap;
  assign epoch_d = wrap && !sync;

  // The init registers are written through so a load coinciding with a restart
  // already seeds the restarted G2 from the new value.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      init_d[c] = init_q[c];
      if (load && (load_ch == CH_W'(c))) begin
        init_d[c] = load_state;
      end
    end
  end

  always_comb begin
    g1_d  = g1_q;
    cnt_d = cnt_q;
    for (int c = 0; c < CHANNELS; c++) begin
      g2_d[c] = g2_q[c];
    end
    if (restart) begin
      g1_d  = G1_INIT;
      cnt_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        g2_d[c] = init_d[c];
      end
    end else if (en) begin
      g1_d  = lfsr_step(g1_q, G1_POLY);
      cnt_d = cnt_q + IDX_W'(1);
      for (int c = 0; c < CHANNELS; c++) begin
        g2_d[c] = lfsr_step(g2_q[c], G2_POLY);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1_q    <= G1_INIT;
      cnt_q   <= '0;
      epoch_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        g2_q[c]   <= G2_INIT;
        init_q[c] <= G2_INIT;
      end
    end else begin
      g1_q    <= g1_d;
      cnt_q   <= cnt_d;
      epoch_q <= epoch_d;
      for (int c = 0; c < CHANNELS; c++) begin
        g2_q[c]   <= g2_d[c];
        init_q[c] <= init_d[c];
      end
    end
  end

  always_comb begin
    chip_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chip_out[c] = g1_q[N-1] ^ g2_q[c][N-1];
    end
  end

  assign chip_idx = cnt_q;
  assign epoch    = epoch_q;

endmodule

// File: tb/tb_gold_code_gen.sv
// Directed bench for gold_code_gen: a default GPS instance, a CODE_LEN=10 instance and a
// three-channel instance, all on one clock and reset.
module tb_gold_code_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en_a, sync_a, load_a, load_ch_a;
  logic [9:0] load_state_a;
  logic [1:0] chip_out_a;
  logic [9:0] chip_idx_a;
  logic       epoch_a;

  logic       en_s, sync_s, load_s, load_ch_s;
  logic [9:0] load_state_s;
  logic [1:0] chip_out_s;
  logic [3:0] chip_idx_s;
  logic       epoch_s;

  logic       en_c, sync_c, load_c;
  logic [1:0] load_ch_c;
  logic [9:0] load_state_c;
  logic [2:0] chip_out_c;
  logic [9:0] chip_idx_c;
  logic       epoch_c;

  gold_code_gen dut_a (
    .clk(clk), .rst(rst), .en(en_a), .sync(sync_a), .load(load_a), .load_ch(load_ch_a),
    .load_state(load_state_a), .chip_out(chip_out_a), .chip_idx(chip_idx_a), .epoch(epoch_a)
  );

  gold_code_gen #(.CODE_LEN(10)) dut_s (
    .clk(clk), .rst(rst), .en(en_s), .sync(sync_s), .load(load_s), .load_ch(load_ch_s),
    .load_state(load_state_s), .chip_out(chip_out_s), .chip_idx(chip_idx_s), .epoch(epoch_s)
  );

  gold_code_gen #(.CHANNELS(3)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .sync(sync_c), .load(load_c), .load_ch(load_ch_c),
    .load_state(load_state_c), .chip_out(chip_out_c), .chip_idx(chip_idx_c), .epoch(epoch_c)
  );

  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  logic prn1 [1023];
  logic alt  [1023];

  // Textbook C/A generator: PRN1 taps G2 stages 2 and 6; alt is G2 stage 10 from all-ones.
  task automatic buildModel();
    logic [10:1] g1m;
    logic [10:1] g2m;
    logic        fb1;
    logic        fb2;
    g1m = '1;
    g2m = '1;
    for (int i = 0; i < 1023; i++) begin
      prn1[i] = g1m[10] ^ g2m[2] ^ g2m[6];
      alt[i]  = g1m[10] ^ g2m[10];
      fb1 = g1m[3] ^ g1m[10];
      fb2 = g2m[2] ^ g2m[3] ^ g2m[6] ^ g2m[8] ^ g2m[9] ^ g2m[10];
      g1m = {g1m[9:1], fb1};
      g2m = {g2m[9:1], fb2};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic sync, input logic load,
                               input logic ch, input logic [9:0] state);
    en_a         = en;
    sync_a       = sync;
    load_a       = load;
    load_ch_a    = ch;
    load_state_a = state;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] first0;
    logic [9:0] first1;
    logic [9:0] pat;
    int         seqErr0, seqErr1, idxErr, epochErr, firstEpoch, epochCount, expIdx, frozenErr;

    pat = 10'b1100100000;
    rst = 1'b1;
    en_a = 0; sync_a = 0; load_a = 0; load_ch_a = 0; load_state_a = '0;
    en_s = 0; sync_s = 0; load_s = 0; load_ch_s = 0; load_state_s = '0;
    en_c = 0; sync_c = 0; load_c = 0; load_ch_c = '0; load_state_c = '0;
    buildModel();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    checkOutput("reset_idx", chip_idx_a, 0);
    checkOutput("reset_epoch", epoch_a, 0);
    checkOutput("reset_chips", chip_out_a, 2'b00);

    // PRN1 on ch0, default init on ch1, then two full epochs with a mid-epoch ch1 reload.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'h0DF);
    checkOutput("load_leaves_running_state", chip_out_a, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
    checkOutput("sync_idx", chip_idx_a, 0);
    checkOutput("sync_epoch", epoch_a, 0);
    checkOutput("sync_first_chips", chip_out_a, 2'b01);

    first0 = {9'b0, chip_out_a[0]};
    first1 = {9'b0, chip_out_a[1]};
    seqErr0 = 0; seqErr1 = 0; idxErr = 0; epochErr = 0; epochCount = 0; firstEpoch = -1;
    for (int i = 1; i <= 2046; i++) begin
      applyStimulus(1'b1, 1'b0, (i == 500), 1'b1, 10'h0DF);
      expIdx = i % 1023;
      if (i <= 9) begin
        first0 = {first0[8:0], chip_out_a[0]};
        first1 = {first1[8:0], chip_out_a[1]};
      end
      if (chip_idx_a !== 10'(expIdx)) idxErr++;
      if (chip_out_a[0] !== prn1[expIdx]) seqErr0++;
      if (chip_out_a[1] !== ((i < 1023) ? alt[expIdx] : prn1[expIdx])) seqErr1++;
      if (epoch_a !== (expIdx == 0)) epochErr++;
      if (epoch_a === 1'b1) begin
        epochCount++;
        if (firstEpoch < 0) firstEpoch = i;
      end
    end
    checkOutput("prn1_first10", first0, 10'b1100100000);
    checkOutput("ch1_first10", first1, 10'b0000000000);
    checkOutput("prn1_seq_errs", seqErr0, 0);
    checkOutput("ch1_reload_seq_errs", seqErr1, 0);
    checkOutput("idx_seq_errs", idxErr, 0);
    checkOutput("epoch_seq_errs", epochErr, 0);
    checkOutput("first_epoch_cycle", firstEpoch, 1023);
    checkOutput("epoch_count", epochCount, 2);

    // Hold en low: everything frozen at chip 5, epoch low.
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
    frozenErr = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
      if (chip_idx_a !== 10'd5 || chip_out_a !== {prn1[5], prn1[5]} || epoch_a !== 1'b0)
        frozenErr++;
    end
    checkOutput("freeze_errs", frozenErr, 0);
    checkOutput("freeze_idx", chip_idx_a, 5);

    // sync beats en mid-epoch and at the last chip.
    repeat (495) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
    checkOutput("advance_to_500", chip_idx_a, 500);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
    checkOutput("sync_en_idx", chip_idx_a, 0);
    checkOutput("sync_en_epoch", epoch_a, 0);
    checkOutput("sync_en_chips", chip_out_a, 2'b11);
    repeat (1022) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
    checkOutput("advance_to_last", chip_idx_a, 1022);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
    checkOutput("sync_at_last_idx", chip_idx_a, 0);
    checkOutput("sync_at_last_epoch", epoch_a, 0);

    // Write-through on load+sync, then on load+wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'h3FF);
    checkOutput("loads_no_restart", chip_out_a, 2'b11);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'h0DF);
    checkOutput("load_sync_writethrough", chip_out_a, 2'b01);
    repeat (1022) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
    checkOutput("advance_to_wrap", chip_idx_a, 1022);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 10'h0DF);
    checkOutput("load_wrap_idx", chip_idx_a, 0);
    checkOutput("load_wrap_epoch", epoch_a, 1);
    checkOutput("load_wrap_writethrough", chip_out_a, 2'b11);

    // Asynchronous reset mid-cycle discards loaded init values too.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_idx", chip_idx_a, 0);
    checkOutput("async_reset_epoch", epoch_a, 0);
    checkOutput("async_reset_chips", chip_out_a, 2'b00);
    en_a = 1'b0;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
    checkOutput("reset_clears_init", chip_out_a, 2'b00);

    // Short cycle: CODE_LEN = 10, PRN1 init on ch0.
    load_s = 1'b1; load_ch_s = 1'b0; load_state_s = 10'h0DF;
    tick();
    load_s = 1'b0; sync_s = 1'b1;
    tick();
    sync_s = 1'b0;
    checkOutput("short_sync_chips", chip_out_s, 2'b01);
    checkOutput("short_sync_idx", chip_idx_s, 0);
    en_s = 1'b1;
    idxErr = 0; seqErr0 = 0; epochErr = 0; epochCount = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      expIdx = i % 10;
      if (chip_idx_s !== 4'(expIdx)) idxErr++;
      if (chip_out_s !== {1'b0, pat[9 - expIdx]}) seqErr0++;
      if (epoch_s !== (expIdx == 0)) epochErr++;
      if (epoch_s === 1'b1) epochCount++;
    end
    en_s = 1'b0;
    checkOutput("short_idx_errs", idxErr, 0);
    checkOutput("short_chip_errs", seqErr0, 0);
    checkOutput("short_epoch_errs", epochErr, 0);
    checkOutput("short_epoch_count", epochCount, 3);

    // Three channels: load_ch = 3 must be ignored.
    load_c = 1'b1; load_ch_c = 2'd2; load_state_c = 10'h0DF;
    tick();
    load_ch_c = 2'd3; load_state_c = 10'h000;
    tick();
    load_c = 1'b0; sync_c = 1'b1;
    tick();
    sync_c = 1'b0;
    checkOutput("oor_first_chips", chip_out_c, 3'b100);
    en_c = 1'b1;
    seqErr0 = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (chip_out_c !== {pat[9 - i], 2'b00}) seqErr0++;
    end
    en_c = 1'b0;
    checkOutput("oor_seq_errs", seqErr0, 0);
    checkOutput("oor_idx", chip_idx_c, 9);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
